// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences one memory-stage request into one or two
// D-cache transactions and returns a single done pulse with load data.
// Indirect requests (LDI/STI) first read a pointer, then access the
// address it holds. Every output comes straight from a register.
module mem_access_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] req_address,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [15:0] req_wdata,
    input  logic        req_indirect,
    input  logic        req_byte,
    input  logic [15:0] dcache_rdata,
    input  logic        dcache_resp,
    output logic [15:0] dcache_address,
    output logic        dcache_read,
    output logic        dcache_write,
    output logic [15:0] dcache_wdata,
    output logic [1:0]  dcache_byte_enable,
    output logic [15:0] rdata,
    output logic        done,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IND  = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Everything the cache sees, kept together so one register drives it.
    typedef struct packed {
        logic [15:0] address;
        logic        read;
        logic        write;
        logic [15:0] wdata;
        logic [1:0]  byte_enable;
    } cache_cmd_t;

    localparam cache_cmd_t CMD_IDLE = '0;

    state_t      state;
    cache_cmd_t  cmd_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic        write_q;
    logic        byte_q;

    // Builds the cache command for a final (non-pointer) access. Byte stores
    // replicate the low byte on both lanes and let the enable pick the lane.
    function automatic cache_cmd_t make_access(input logic [15:0] addr,
                                               input logic        write,
                                               input logic        byte_acc,
                                               input logic [15:0] wdata);
        cache_cmd_t c;
        c.address = {addr[15:1], 1'b0};
        c.read    = ~write;
        c.write   = write;
        if (byte_acc) begin
            c.wdata       = write ? {wdata[7:0], wdata[7:0]} : 16'h0000;
            c.byte_enable = addr[0] ? 2'b10 : 2'b01;
        end else begin
            c.wdata       = write ? wdata : 16'h0000;
            c.byte_enable = 2'b11;
        end
        return c;
    endfunction

    // Pointer fetch for LDI/STI: always a word read, never a write.
    function automatic cache_cmd_t make_pointer_read(input logic [15:0] addr);
        cache_cmd_t c;
        c.address     = {addr[15:1], 1'b0};
        c.read        = 1'b1;
        c.write       = 1'b0;
        c.wdata       = 16'h0000;
        c.byte_enable = 2'b11;
        return c;
    endfunction

    // Byte loads pick the lane by address bit 0 and sign-extend it.
    function automatic logic [15:0] align_load(input logic [15:0] data,
                                               input logic        byte_acc,
                                               input logic        odd);
        logic [7:0] lane;
        lane = odd ? data[15:8] : data[7:0];
        return byte_acc ? {{8{lane[7]}}, lane} : data;
    endfunction

    // Sequencer: state, latched request, cache command and results.
    // NOTE: state registers use non-blocking assignments so every flop in this
    // block samples the values from before the clock edge, regardless of order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cmd_q   <= CMD_IDLE;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            write_q <= 1'b0;
            byte_q  <= 1'b0;
            rdata   <= 16'h0000;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_read || req_write) begin
                        // A request with both flags set is treated as a store.
                        addr_q  <= req_address;
                        wdata_q <= req_wdata;
                        write_q <= req_write;
                        byte_q  <= req_byte & ~req_indirect;
                        busy    <= 1'b1;
                        if (req_indirect) begin
                            state <= IND;
                            cmd_q <= make_pointer_read(req_address);
                        end else begin
                            state <= ACC;
                            cmd_q <= make_access(req_address, req_write, req_byte,
                                                 req_wdata);
                        end
                    end
                end
                IND: begin
                    if (dcache_resp) begin
                        // The pointer becomes the final address; indirect
                        // accesses are always word-sized.
                        addr_q <= {dcache_rdata[15:1], 1'b0};
                        state  <= ACC;
                        cmd_q  <= make_access({dcache_rdata[15:1], 1'b0}, write_q,
                                              1'b0, wdata_q);
                    end
                end
                ACC: begin
                    if (dcache_resp) begin
                        if (!write_q) begin
                            rdata <= align_load(dcache_rdata, byte_q, addr_q[0]);
                        end
                        state <= DONE;
                        cmd_q <= CMD_IDLE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    cmd_q <= CMD_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign dcache_address     = cmd_q.address;
    assign dcache_read        = cmd_q.read;
    assign dcache_write       = cmd_q.write;
    assign dcache_wdata       = cmd_q.wdata;
    assign dcache_byte_enable = cmd_q.byte_enable;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed tests for mem_access_ctrl with hand-computed
// expected values for word/byte loads and stores, LDI/STI, and reset abort.
module tb_mem_access_ctrl;

    logic        clk;
    logic        reset;
    logic [15:0] req_address;
    logic        req_read;
    logic        req_write;
    logic [15:0] req_wdata;
    logic        req_indirect;
    logic        req_byte;
    logic [15:0] dcache_rdata;
    logic        dcache_resp;
    logic [15:0] dcache_address;
    logic        dcache_read;
    logic        dcache_write;
    logic [15:0] dcache_wdata;
    logic [1:0]  dcache_byte_enable;
    logic [15:0] rdata;
    logic        done;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int done_count = 0;

    mem_access_ctrl dut (
        .clk                (clk),
        .reset              (reset),
        .req_address        (req_address),
        .req_read           (req_read),
        .req_write          (req_write),
        .req_wdata          (req_wdata),
        .req_indirect       (req_indirect),
        .req_byte           (req_byte),
        .dcache_rdata       (dcache_rdata),
        .dcache_resp        (dcache_resp),
        .dcache_address     (dcache_address),
        .dcache_read        (dcache_read),
        .dcache_write       (dcache_write),
        .dcache_wdata       (dcache_wdata),
        .dcache_byte_enable (dcache_byte_enable),
        .rdata              (rdata),
        .done               (done),
        .busy               (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (done === 1'b1) done_count++;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one cycle; outputs are settled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        req_address  = 16'h0;
        req_read     = 1'b0;
        req_write    = 1'b0;
        req_wdata    = 16'h0;
        req_indirect = 1'b0;
        req_byte     = 1'b0;
    endtask

    task automatic expect_done(input string tag, input logic [15:0] exp_rdata);
        check({tag, ".done"}, done, 1);
        check({tag, ".rd_off"}, dcache_read, 0);
        check({tag, ".wr_off"}, dcache_write, 0);
        check({tag, ".busy_done"}, busy, 1);
        check({tag, ".rdata"}, rdata, exp_rdata);
        clear_req();
        tick();
        check({tag, ".done_low"}, done, 0);
        check({tag, ".busy_low"}, busy, 0);
        check({tag, ".rdata_hold"}, rdata, exp_rdata);
    endtask

    // Direct access; the cache answers in the n-th strobe cycle.
    task automatic single_access(input string tag, input logic rd, input logic wr,
                                 input logic byt, input logic [15:0] addr,
                                 input logic [15:0] wd, input int n,
                                 input logic [15:0] cdata, input logic [15:0] exp_addr,
                                 input logic [15:0] exp_wdata, input logic [1:0] exp_be,
                                 input logic [15:0] exp_rdata);
        int dc0;
        dc0 = done_count;
        req_address = addr; req_read = rd; req_write = wr;
        req_wdata = wd; req_byte = byt; req_indirect = 1'b0;
        check({tag, ".busy_idle"}, busy, 0);
        for (int k = 1; k <= n; k++) begin
            tick();
            check({tag, ".rd"}, dcache_read, !wr);
            check({tag, ".wr"}, dcache_write, wr);
            check({tag, ".addr"}, dcache_address, exp_addr);
            if (wr || !byt) check({tag, ".be"}, dcache_byte_enable, exp_be);
            if (wr) check({tag, ".wdata"}, dcache_wdata, exp_wdata);
            check({tag, ".no_done"}, done, 0);
            check({tag, ".busy"}, busy, 1);
            if (k == n) begin
                dcache_resp = 1'b1;
                dcache_rdata = cdata;
            end
        end
        tick();
        dcache_resp = 1'b0;
        dcache_rdata = 16'h0;
        expect_done(tag, exp_rdata);
        check({tag, ".one_done"}, done_count - dc0, 1);
    endtask

    // Indirect access: pointer read for n1 cycles, then final access for n2.
    task automatic ind_access(input string tag, input logic wr, input logic [15:0] addr,
                              input logic [15:0] wd, input int n1, input logic [15:0] ptr,
                              input int n2, input logic [15:0] cdata,
                              input logic [15:0] exp_addr, input logic [15:0] exp_rdata);
        int dc0;
        dc0 = done_count;
        req_address = addr; req_read = !wr; req_write = wr;
        req_wdata = wd; req_byte = 1'b1; req_indirect = 1'b1;
        for (int k = 1; k <= n1; k++) begin
            tick();
            check({tag, ".p_rd"}, dcache_read, 1);
            check({tag, ".p_wr"}, dcache_write, 0);
            check({tag, ".p_addr"}, dcache_address, {addr[15:1], 1'b0});
            check({tag, ".p_busy"}, busy, 1);
            if (k == n1) begin
                dcache_resp = 1'b1;
                dcache_rdata = ptr;
            end
        end
        for (int k = 1; k <= n2; k++) begin
            tick();
            dcache_resp = 1'b0;
            check({tag, ".f_rd"}, dcache_read, !wr);
            check({tag, ".f_wr"}, dcache_write, wr);
            check({tag, ".f_addr"}, dcache_address, exp_addr);
            check({tag, ".f_be"}, dcache_byte_enable, 2'b11);
            if (wr) check({tag, ".f_wdata"}, dcache_wdata, wd);
            check({tag, ".f_no_done"}, done, 0);
            if (k == n2) begin
                dcache_resp = 1'b1;
                dcache_rdata = cdata;
            end
        end
        tick();
        dcache_resp = 1'b0;
        dcache_rdata = 16'h0;
        expect_done(tag, exp_rdata);
        check({tag, ".one_done"}, done_count - dc0, 1);
    endtask

    initial begin
        clear_req();
        dcache_rdata = 16'h0;
        dcache_resp  = 1'b0;
        reset        = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        check("rst.state_busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.rdata", rdata, 16'h0);
        check("rst.addr", dcache_address, 16'h0);
        check("rst.strobes", {dcache_read, dcache_write}, 2'b00);
        check("rst.wdata_be", {dcache_wdata, dcache_byte_enable}, 18'h0);

        // LDR word, response after 2 cycles: done in cycle 3.
        single_access("ldr", 1, 0, 0, 16'h3005, 16'h0, 2, 16'hBEEF,
                      16'h3004, 16'h0, 2'b11, 16'hBEEF);
        // LDB odd / even, zero-wait: done in cycle 2.
        single_access("ldb_odd", 1, 0, 1, 16'h1001, 16'h0, 1, 16'h80FF,
                      16'h1000, 16'h0, 2'b10, 16'hFF80);
        single_access("ldb_even", 1, 0, 1, 16'h1000, 16'h0, 1, 16'h80FF,
                      16'h1000, 16'h0, 2'b01, 16'hFFFF);
        // STB high lane; rdata untouched even though the cache returns data.
        single_access("stb", 0, 1, 1, 16'h2003, 16'h1234, 1, 16'h5555,
                      16'h2002, 16'h3434, 2'b10, 16'hFFFF);

        // Response while idle is ignored.
        dcache_resp = 1'b1;
        dcache_rdata = 16'h1111;
        tick();
        dcache_resp = 1'b0;
        check("idle_resp.busy", busy, 0);
        check("idle_resp.rdata", rdata, 16'hFFFF);
        check("idle_resp.strobe", dcache_read, 0);

        // Both read and write set: store wins, word write.
        single_access("str_wins", 1, 1, 0, 16'h2101, 16'hABCD, 3, 16'h0000,
                      16'h2100, 16'hABCD, 2'b11, 16'hFFFF);
        // Positive byte loads.
        single_access("ldb_pos_lo", 1, 0, 1, 16'h1000, 16'h0, 3, 16'h1234,
                      16'h1000, 16'h0, 2'b01, 16'h0034);
        single_access("ldb_pos_hi", 1, 0, 1, 16'h1001, 16'h0, 1, 16'h7F00,
                      16'h1000, 16'h0, 2'b10, 16'h007F);

        // LDI with req_byte set: byte flag must be ignored (word result).
        ind_access("ldi", 0, 16'h4000, 16'h0, 2, 16'h5001, 1, 16'h00A5,
                   16'h5000, 16'h00A5);
        // STI: write of CAFE at 0x6000, rdata keeps the last load.
        ind_access("sti", 1, 16'h4000, 16'hCAFE, 1, 16'h6000, 2, 16'h0000,
                   16'h6000, 16'h00A5);

        // Reset in the middle of an LDI pointer read.
        begin
            int dc0;
            dc0 = done_count;
            req_address = 16'h4000; req_read = 1'b1; req_indirect = 1'b1;
            tick();
            check("abort.ind_rd", dcache_read, 1);
            #2;
            reset = 1'b1;
            #1;
            check("abort.rd_drop", dcache_read, 0);
            check("abort.wr_drop", dcache_write, 0);
            check("abort.busy", busy, 0);
            check("abort.done", done, 0);
            clear_req();
            tick();
            reset = 1'b0;
            for (int k = 0; k < 3; k++) tick();
            check("abort.no_done", done_count - dc0, 0);
            check("abort.rdata_rst", rdata, 16'h0);
        end
        single_access("ldr_after", 1, 0, 0, 16'h0043, 16'h0, 1, 16'h1357,
                      16'h0042, 16'h0, 2'b11, 16'h1357);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
